// File: rtl/data_mem_pkg.sv
// Shared definitions for the pipelined data memory: FSM encoding and the
// range of supported read latencies.
package data_mem_pkg;

   // Init sweep followed by normal operation; only reset leaves ST_RUN.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   function automatic bit rd_lat_legal(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO. Depth need not be a power of two; pointers wrap
// explicitly. Output data reads as zero while the FIFO is empty.
module rsp_fifo
   import data_mem_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage write on push.
   // NOTE: storage has no reset; contents are only observed behind o_empty,
   // so clearing it would cost flops and buy nothing.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/data_memory_pipe.sv
// Pipelined single-port data memory with masked writes, a registered read
// path of 1 or 2 cycles, credit-protected response FIFO and a post-reset
// sweep that fills every word with INIT_VAL before requests are accepted.
module data_memory_pipe
   import data_mem_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 8,
   parameter int                RD_LAT    = 1,
   parameter logic [DATA_W-1:0] INIT_VAL  = '0,
   parameter int                RSP_DEPTH = RD_LAT + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_done,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_wmask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CRD_W = $clog2(RSP_DEPTH + 1);

   if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("data_memory_pipe: RD_LAT must be 1 or 2");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];
   state_e            r_state;
   state_e            w_next_state;
   logic [ADDR_W-1:0] r_init_cnt;
   logic              r_init_done;
   logic [CRD_W-1:0]  r_credits;
   logic              r_rd_vld;
   logic [DATA_W-1:0] r_rd_data;
   logic              w_init_we;
   logic              w_run;
   logic              w_req_ready;
   logic              w_rd_accept;
   logic              w_wr_accept;
   logic              w_rsp_pop;
   logic              w_push;
   logic [DATA_W-1:0] w_push_data;
   logic              w_fifo_full;
   logic              w_fifo_empty;

   assign w_req_ready = w_run && (r_credits != '0);
   assign w_rd_accept = req_valid && w_req_ready && !req_write;
   assign w_wr_accept = req_valid && w_req_ready && req_write;
   assign w_rsp_pop   = !w_fifo_empty && rsp_ready;

   assign req_ready = w_req_ready;
   assign rsp_valid = !w_fifo_empty;
   assign init_done = r_init_done;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_INIT;
      else        r_state <= w_next_state;
   end

   // FSM next state: leave the sweep after the last word has been written.
   // NOTE: the default assignment up front keeps this block free of latches.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_INIT: if (r_init_cnt == ADDR_W'(DEPTH - 1)) w_next_state = ST_RUN;
         ST_RUN:  w_next_state = ST_RUN;
         default: w_next_state = ST_INIT;
      endcase
   end

   // FSM outputs: sweep write enable and run qualifier.
   always_comb begin
      w_init_we = 1'b0;
      w_run     = 1'b0;
      case (r_state)
         ST_INIT: w_init_we = 1'b1;
         ST_RUN:  w_run     = 1'b1;
         default: w_init_we = 1'b0;
      endcase
   end

   // Sweep address counter and registered completion flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_init_cnt  <= '0;
         r_init_done <= 1'b0;
      end else begin
         if (w_init_we) r_init_cnt <= r_init_cnt + 1'b1;
         r_init_done <= (w_next_state == ST_RUN);
      end
   end

   // Array: sweep or masked write, plus the registered read port.
   always_ff @(posedge clk) begin
      if (w_init_we) begin
         r_mem[r_init_cnt] <= INIT_VAL;
      end else if (w_wr_accept) begin
         r_mem[req_addr] <= (r_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
      end
      if (w_rd_accept) r_rd_data <= r_mem[req_addr];
   end

   // First read stage valid; data rides alongside in the array block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd_vld <= 1'b0;
      else        r_rd_vld <= w_rd_accept;
   end

   if (RD_LAT == 2) begin : g_lat2
      logic              r_out_vld;
      logic [DATA_W-1:0] r_out_data;

      // Extra output register stage for the two-cycle read path.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
         end else begin
            r_out_vld  <= r_rd_vld;
            r_out_data <= r_rd_data;
         end
      end

      assign w_push      = r_out_vld;
      assign w_push_data = r_out_data;
   end else begin : g_lat1
      assign w_push      = r_rd_vld;
      assign w_push_data = r_rd_data;
   end

   // Credits: one per outstanding read, returned when its response is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credits <= CRD_W'(RSP_DEPTH);
      end else begin
         case ({w_rd_accept, w_rsp_pop})
            2'b10:   r_credits <= r_credits - 1'b1;
            2'b01:   r_credits <= r_credits + 1'b1;
            default: r_credits <= r_credits;
         endcase
      end
   end

   rsp_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push && !w_fifo_full),
      .i_pop   (w_rsp_pop),
      .i_data  (w_push_data),
      .o_data  (rsp_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

endmodule
